// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan decoder family: segment
// patterns (active-high gfedcba), FSM state encoding and the default digit count.
package seg_pkg;

  localparam int DEFAULT_DIGITS = 8;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment (active-high gfedcba) to hex nibble decoder;
// valid drops for any pattern outside the 16 hex glyphs.
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the displayed number from a multiplexed 7-seg scan (AN/SEG).
// Define SEG_DP_CAPTURE_EN to also capture decimal points on a dp output.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     AN,
  input  logic [7:0]            SEG,
  output logic [4*DIGITS-1:0]   value,
  output logic                  frame_valid,
  output logic                  frame_changed,
`ifdef SEG_DP_CAPTURE_EN
  output logic [DIGITS-1:0]     dp,
`endif
  output logic                  frame_err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);
`ifdef SEG_DP_CAPTURE_EN
  localparam logic [7:0] SEG_MASK = 8'hFF;
`else
  localparam logic [7:0] SEG_MASK = 8'h7F;
`endif

  logic [DIGITS-1:0]   s_an, p_an, an_lo;
  logic [7:0]          s_seg, p_seg;
  logic                sel_ok, same;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          dec_nib;
  logic                dec_ok;

  state_t              state, state_n;
  logic [7:0]          cnt, cnt_n;
  logic                capture;

  logic [4*DIGITS-1:0] work, prev, new_frame;
  logic [DIGITS-1:0]   seen, new_seen;
  logic                err_acc;

  // Sample stage: one register on AN/SEG plus a second copy for the stability compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_an  <= '1;
      s_seg <= SEG_MASK;
      p_an  <= '1;
      p_seg <= SEG_MASK;
    end else begin
      s_an  <= AN;
      s_seg <= SEG & SEG_MASK;
      p_an  <= s_an;
      p_seg <= s_seg;
    end
  end

  assign an_lo  = ~s_an;
  assign sel_ok = (an_lo != '0) && ((an_lo & (an_lo - 1'b1)) == '0);
  assign same   = (s_an == p_an) && (s_seg == p_seg);

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!s_an[i]) idx = IDX_W'(i);
  end

  seg7_to_hex u_dec (
    .pattern (~s_seg[6:0]),
    .nibble  (dec_nib),
    .valid   (dec_ok)
  );

  // Dwell tracking: a digit is captured once per dwell after STABLE_CYCLES equal samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEARCH;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      SEARCH: begin
        if (sel_ok) begin
          cnt_n   = 8'd1;
          state_n = (STABLE_LIM == 8'd1) ? HOLD : SETTLE;
          capture = (STABLE_LIM == 8'd1);
        end
      end
      SETTLE: begin
        if (same) begin
          if (({1'b0, cnt} + 9'd1) >= {1'b0, STABLE_LIM}) begin
            capture = 1'b1;
            state_n = HOLD;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else if (sel_ok) begin
          cnt_n   = 8'd1;
          state_n = (STABLE_LIM == 8'd1) ? HOLD : SETTLE;
          capture = (STABLE_LIM == 8'd1);
        end else begin
          state_n = SEARCH;
        end
      end
      HOLD: begin
        if (!same) begin
          if (sel_ok) begin
            cnt_n   = 8'd1;
            state_n = (STABLE_LIM == 8'd1) ? HOLD : SETTLE;
            capture = (STABLE_LIM == 8'd1);
          end else begin
            state_n = SEARCH;
          end
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_comb begin
    new_frame = work;
    new_frame[int'(idx)*4 +: 4] = dec_ok ? dec_nib : 4'h0;
    new_seen = seen;
    new_seen[idx] = 1'b1;
  end

`ifdef SEG_DP_CAPTURE_EN
  logic [DIGITS-1:0] work_dp, prev_dp, new_dp;

  always_comb begin
    new_dp = work_dp;
    new_dp[idx] = ~s_seg[7];
  end
`endif

  // Frame assembly: the capture completing the seen mask publishes the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work          <= '0;
      prev          <= '0;
      seen          <= '0;
      err_acc       <= 1'b0;
      value         <= '0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      frame_err     <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      work_dp       <= '0;
      prev_dp       <= '0;
      dp            <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      if (capture) begin
        work <= new_frame;
`ifdef SEG_DP_CAPTURE_EN
        work_dp <= new_dp;
`endif
        if (&new_seen) begin
          value       <= new_frame;
          prev        <= new_frame;
          frame_valid <= 1'b1;
          frame_err   <= err_acc | ~dec_ok;
          seen        <= '0;
          err_acc     <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
          dp            <= new_dp;
          prev_dp       <= new_dp;
          frame_changed <= {new_dp, new_frame} != {prev_dp, prev};
`else
          frame_changed <= new_frame != prev;
`endif
        end else begin
          seen    <= new_seen;
          err_acc <= err_acc | ~dec_ok;
        end
      end
    end
  end

endmodule
